// File: rtl/skew_pkg.sv
// Shared types and sizing helpers for the diagonal skew feeder.
package skew_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2
    } skew_state_t;

    localparam int unsigned DEF_DIM  = 8;
    localparam int unsigned DEF_BITS = 8;

    // Drain counter width: $clog2(dim), never below one bit.
    function automatic int unsigned drain_cnt_w(input int unsigned dim);
        return (dim > 1) ? $clog2(dim) : 1;
    endfunction

endpackage

// File: rtl/skew_feeder_lane.sv
// One lane of the skew: an enabled shift chain cleared by synchronous reset.
module skew_lane #(
    parameter int unsigned STAGES = 1,
    parameter int unsigned BITS   = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [BITS-1:0] d,
    output logic [BITS-1:0] q
);

    logic [STAGES-1:0][BITS-1:0] stage_q;
    logic [STAGES-1:0][BITS-1:0] stage_d;

    // Advance the chain by one stage on enable, otherwise hold every stage.
    always_comb begin
        stage_d = stage_q;
        if (en) begin
            stage_d[0] = d;
            for (int k = 1; k < int'(STAGES); k++) begin
                stage_d[k] = stage_q[k-1];
            end
        end
    end

    // Stage registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/skew_feeder.sv
// Diagonal skew stage: lane i of each accepted vector is delayed i extra shifts,
// then the block self-drains with zero vectors and pulses done on the last output.
module skew_feeder
    import skew_pkg::*;
#(
    parameter int unsigned DIM  = DEF_DIM,
    parameter int unsigned BITS = DEF_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DIM*BITS-1:0] in_vec,
    input  logic                in_last,
    output logic                out_valid,
    output logic [DIM*BITS-1:0] out_vec,
    output logic                busy,
    output logic                done
);

    localparam int unsigned CNT_W    = drain_cnt_w(DIM);
    localparam int unsigned LAST_CNT = (DIM > 1) ? DIM - 2 : 0;

    typedef logic [BITS-1:0] lane_t;

    skew_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic             accept;
    logic             shift;
    logic             draining;
    lane_t            lane_in  [DIM];
    lane_t            lane_out [DIM];

    // Handshake and shift qualification; nothing is accepted while draining or in reset.
    always_comb begin
        draining = (state_q == DRAIN);
        in_ready = !rst && !draining;
        accept   = in_valid && in_ready;
        shift    = accept || draining;
    end

    // Next-state, drain counter and registered-output inputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE, FEED: begin
                if (accept) begin
                    if (in_last) begin
                        if (DIM == 1) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = DRAIN;
                            cnt_d   = '0;
                        end
                    end else begin
                        state_d = FEED;
                    end
                end
            end
            DRAIN: begin
                if (cnt_q == CNT_W'(LAST_CNT)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        out_valid_d = shift;
        busy_d      = (state_d != IDLE);
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    // Lane i gets i+1 stages; drain cycles feed zeros.
    for (genvar i = 0; i < int'(DIM); i++) begin : g_lane
        assign lane_in[i] = draining ? '0 : in_vec[i*BITS +: BITS];

        skew_lane #(
            .STAGES(i + 1),
            .BITS  (BITS)
        ) u_lane (
            .clk(clk),
            .rst(rst),
            .en (shift),
            .d  (lane_in[i]),
            .q  (lane_out[i])
        );
    end

    // Pack lane outputs back into the vector bus.
    always_comb begin
        out_vec = '0;
        for (int i = 0; i < int'(DIM); i++) begin
            out_vec[i*BITS +: BITS] = lane_out[i];
        end
    end

    assign out_valid = out_valid_q;
    assign done      = done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_skew_feeder.sv
// Directed bench for skew_feeder at DIM=4 and DIM=1 (BITS=8).
module tb_skew_feeder;

    logic        clk = 1'b0;
    logic        rst;

    logic        valid4, ready4, last4, ov4, busy4, done4;
    logic [31:0] vec4, ovec4;

    logic        valid1, ready1, last1, ov1, busy1, done1;
    logic [7:0]  vec1, ovec1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    skew_feeder #(.DIM(4), .BITS(8)) u_dut4 (
        .clk(clk), .rst(rst),
        .in_valid(valid4), .in_ready(ready4), .in_vec(vec4), .in_last(last4),
        .out_valid(ov4), .out_vec(ovec4), .busy(busy4), .done(done4)
    );

    skew_feeder #(.DIM(1), .BITS(8)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(valid1), .in_ready(ready1), .in_vec(vec1), .in_last(last1),
        .out_valid(ov1), .out_vec(ovec1), .busy(busy1), .done(done1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Lane i of input vector k for a stimulus pattern.
    function automatic logic [7:0] pat(input int mode, input int k, input int i);
        case (mode)
            0:       return 8'(16 * k + i);
            1:       return 8'hAA;
            default: return 8'(8'hE0 + i);
        endcase
    endfunction

    // Expected out_vec for shift m of an n-vector matrix: lane i carries vector m-i.
    function automatic logic [31:0] exp4(input int mode, input int n, input int m);
        logic [31:0] r = '0;
        for (int i = 0; i < 4; i++) begin
            if (m - i >= 0 && m - i < n) r[i*8 +: 8] = pat(mode, m - i, i);
        end
        return r;
    endfunction

    task automatic cyc4(input bit v, input bit l, input int mode, input int k);
        valid4 = v;
        last4  = l;
        for (int i = 0; i < 4; i++) vec4[i*8 +: 8] = pat(mode, k, i);
        @(posedge clk);
        #1;
        valid4 = 1'b0;
        last4  = 1'b0;
    endtask

    task automatic chk_pulse(input string tag, input int mode, input int n, input int m, input bit dn);
        chk($sformatf("%s m%0d valid", tag, m), 32'(ov4), 1);
        chk($sformatf("%s m%0d vec", tag, m), ovec4, exp4(mode, n, m));
        chk($sformatf("%s m%0d done", tag, m), 32'(done4), 32'(dn));
    endtask

    task automatic chk_quiet(input string tag);
        chk($sformatf("%s valid", tag), 32'(ov4), 0);
        chk($sformatf("%s done", tag), 32'(done4), 0);
    endtask

    initial begin
        rst    = 1'b1;
        valid4 = 1'b1; last4 = 1'b0; vec4 = 32'hFFFF_FFFF;
        valid1 = 1'b1; last1 = 1'b0; vec1 = 8'hFF;

        // Reset held three cycles with input offered.
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk("rst out_valid", 32'(ov4), 0);
            chk("rst out_vec", ovec4, 0);
            chk("rst in_ready", 32'(ready4), 0);
            chk("rst busy", 32'(busy4), 0);
            chk("rst done", 32'(done4), 0);
            chk("rst1 out_valid", 32'(ov1), 0);
        end
        rst = 1'b0; valid4 = 1'b0; valid1 = 1'b0;
        #1;
        chk("post-rst in_ready", 32'(ready4), 1);
        chk("post-rst in_ready dim1", 32'(ready1), 1);

        // DIM=1: two vectors, no drain.
        valid1 = 1'b1; vec1 = 8'h5A; last1 = 1'b0;
        @(posedge clk); #1;
        chk("d1 p0 valid", 32'(ov1), 1);
        chk("d1 p0 vec", 32'(ovec1), 32'h5A);
        chk("d1 p0 done", 32'(done1), 0);
        chk("d1 p0 busy", 32'(busy1), 1);
        vec1 = 8'hC3; last1 = 1'b1;
        @(posedge clk); #1;
        valid1 = 1'b0; last1 = 1'b0;
        chk("d1 p1 valid", 32'(ov1), 1);
        chk("d1 p1 vec", 32'(ovec1), 32'hC3);
        chk("d1 p1 done", 32'(done1), 1);
        chk("d1 p1 busy", 32'(busy1), 0);
        chk("d1 p1 in_ready", 32'(ready1), 1);
        @(posedge clk); #1;
        chk("d1 idle valid", 32'(ov1), 0);
        chk("d1 idle done", 32'(done1), 0);

        // Single matrix, back-to-back vectors.
        for (int k = 0; k < 4; k++) begin
            cyc4(1'b1, k == 3, 0, k);
            chk_pulse("b2b", 0, 4, k, 1'b0);
            chk($sformatf("b2b k%0d busy", k), 32'(busy4), 1);
            chk($sformatf("b2b k%0d in_ready", k), 32'(ready4), 32'(k != 3));
        end
        for (int d = 0; d < 3; d++) begin
            cyc4(1'b0, 1'b0, 0, 0);
            chk_pulse("b2b drain", 0, 4, 4 + d, d == 2);
            chk($sformatf("b2b drain%0d in_ready", d), 32'(ready4), 32'(d == 2));
        end
        cyc4(1'b0, 1'b0, 0, 0);
        chk_quiet("b2b after");
        chk("b2b after busy", 32'(busy4), 0);

        // Same matrix with a two-cycle gap after V1.
        cyc4(1'b1, 1'b0, 0, 0);
        chk_pulse("gap", 0, 4, 0, 1'b0);
        cyc4(1'b1, 1'b0, 0, 1);
        chk_pulse("gap", 0, 4, 1, 1'b0);
        for (int g = 0; g < 2; g++) begin
            cyc4(1'b0, 1'b0, 0, 0);
            chk_quiet($sformatf("gap idle%0d", g));
            chk($sformatf("gap idle%0d hold", g), ovec4, exp4(0, 4, 1));
        end
        cyc4(1'b1, 1'b0, 0, 2);
        chk_pulse("gap", 0, 4, 2, 1'b0);
        cyc4(1'b1, 1'b1, 0, 3);
        chk_pulse("gap", 0, 4, 3, 1'b0);
        for (int d = 0; d < 3; d++) begin
            cyc4(1'b0, 1'b0, 0, 0);
            chk_pulse("gap drain", 0, 4, 4 + d, d == 2);
        end
        cyc4(1'b0, 1'b0, 0, 0);
        chk_quiet("gap after");

        // Reset on the second drain cycle, then a one-vector matrix.
        for (int k = 0; k < 4; k++) cyc4(1'b1, k == 3, 0, k);
        cyc4(1'b0, 1'b0, 0, 0);
        chk_pulse("rstd drain", 0, 4, 4, 1'b0);
        rst = 1'b1;
        cyc4(1'b0, 1'b0, 0, 0);
        chk_quiet("rstd in rst");
        chk("rstd vec", ovec4, 0);
        chk("rstd busy", 32'(busy4), 0);
        rst = 1'b0;
        cyc4(1'b0, 1'b0, 0, 0);
        chk_quiet("rstd post");
        chk("rstd post vec", ovec4, 0);
        chk("rstd post in_ready", 32'(ready4), 1);
        cyc4(1'b1, 1'b1, 1, 0);
        chk_pulse("aa", 1, 1, 0, 1'b0);
        for (int d = 1; d < 4; d++) begin
            cyc4(1'b0, 1'b0, 0, 0);
            chk_pulse("aa", 1, 1, d, d == 3);
        end

        // Matrix B offered during A's drain is held off until IDLE.
        cyc4(1'b1, 1'b0, 0, 0);
        chk_pulse("mA", 0, 2, 0, 1'b0);
        cyc4(1'b1, 1'b1, 0, 1);
        chk_pulse("mA", 0, 2, 1, 1'b0);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("mA drain%0d in_ready", d), 32'(ready4), 0);
            cyc4(1'b1, 1'b1, 2, 0);
            chk_pulse("mA drain", 0, 2, 2 + d, d == 2);
        end
        chk("mB in_ready", 32'(ready4), 1);
        cyc4(1'b1, 1'b1, 2, 0);
        chk_pulse("mB", 2, 1, 0, 1'b0);
        for (int d = 1; d < 4; d++) begin
            cyc4(1'b0, 1'b0, 0, 0);
            chk_pulse("mB", 2, 1, d, d == 3);
        end
        cyc4(1'b0, 1'b0, 0, 0);
        chk_quiet("mB after");
        chk("mB after busy", 32'(busy4), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
